// File: rtl/neo_lb_pkg.sv
// neo_lb_pkg -- shared definitions for the sprite line-buffer control sequencer.
//   lb_state_e      render FSM state encoding
//   SPR_W_DEF/VIS_W default sprite width / visible line width (pixels)
//   PB_*_LSB        PBUS_OUT field offsets: {PAL[7:0], R addr[7:0], L addr[7:0]}
//   pbus_pack()     assembles a PBUS word from its three fields
package neo_lb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LINIT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WA    = 3'd3,
    ST_WB    = 3'd4
  } lb_state_e;

  localparam int SPR_W_DEF  = 16;
  localparam int VIS_W_DEF  = 320;

  localparam int PB_L_LSB   = 0;
  localparam int PB_R_LSB   = 8;
  localparam int PB_PAL_LSB = 16;
  localparam int PB_W       = 24;

  function automatic logic [PB_W-1:0] pbus_pack(input logic [7:0] pal,
                                                input logic [7:0] r_addr,
                                                input logic [7:0] l_addr);
    logic [PB_W-1:0] w;
    w = '0;
    w[PB_PAL_LSB +: 8] = pal;
    w[PB_R_LSB   +: 8] = r_addr;
    w[PB_L_LSB   +: 8] = l_addr;
    return w;
  endfunction

endpackage

// File: rtl/neo_lb_ctrl_disp.sv
// neo_lb_ctrl_disp -- display-side (front pair) strobe generator.
// The front pair is read out by the palette stage; its address counters
// advance once per pixel pair, i.e. on every second PIX_EN tick of the
// visible region, and its clear-after-read enables follow DISP_ACTIVE.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_pix_en             one-clock pixel tick
//   i_disp               DISP_ACTIVE
//   i_tms0               flip; 0 = pair 1 is front
//   o_ck_p1, o_ck_p2     front-pair counter clock, pair 1 / pair 2
//   o_ss1, o_ss2         clear-after-read enables, pair 1 / pair 2
module neo_lb_ctrl_disp (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pix_en,
  input  logic i_disp,
  input  logic i_tms0,
  output logic o_ck_p1,
  output logic o_ck_p2,
  output logic o_ss1,
  output logic o_ss2
);

  logic r_ph;   // pixel phase within a pair; clocks on the odd (second) tick
  logic w_ck;

  // Phase restarts whenever the visible region ends so every line's first
  // counter clock lands on its second visible pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_ph <= 1'b0;
    else if (!i_disp)  r_ph <= 1'b0;
    else if (i_pix_en) r_ph <= ~r_ph;
  end

  assign w_ck    = i_pix_en & i_disp & r_ph;
  assign o_ck_p1 = w_ck & ~i_tms0;
  assign o_ck_p2 = w_ck &  i_tms0;
  assign o_ss1   = i_disp & ~i_tms0;
  assign o_ss2   = i_disp &  i_tms0;

endmodule

// File: rtl/neo_lb_ctrl.sv
// neo_lb_ctrl -- sprite line-buffer control sequencer (writer side).
// Renders one sprite job at a time into the back line-buffer pair while the
// front pair is read out and cleared; LINE_START flips the pairs.
// Optional build macro: NEO_LB_CLIP_EN -- when defined, writes for pixels at
// X >= VIS_W are suppressed (counter clocks still run).
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   PIX_EN                 one-clock pixel tick
//   LINE_START             line-start pulse, qualified by PIX_EN
//   DISP_ACTIVE            visible part of the line
//   JOB_VALID/JOB_READY    job handshake; JOB_X sprite left X, JOB_PAL palette
//   GAD, GBD               current pixel pair (0 = transparent)
//   PBUS_OUT/PBUS_OE       {PAL, R addr, L addr} and its drive enable
//   PXSWAP                 JOB_X[0] of the active job
//   LD1/LD2                address-load strobes, pair 1 / pair 2
//   CK1..CK4, WE1..WE4     counter clocks / write strobes for BL, BR, TL, TR
//   SS1/SS2                clear-after-read enables
//   TMS0                   flip; 0 = pair 1 displayed, pair 2 rendered
//   PCK2                   sprite palette latch pulse
//   LATE_CNT               saturating count of aborted jobs
module neo_lb_ctrl
  import neo_lb_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int VIS_W = VIS_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             PIX_EN,
  input  logic             LINE_START,
  input  logic             DISP_ACTIVE,
  input  logic             JOB_VALID,
  output logic             JOB_READY,
  input  logic [8:0]       JOB_X,
  input  logic [7:0]       JOB_PAL,
  input  logic [3:0]       GAD,
  input  logic [3:0]       GBD,
  output logic [PB_W-1:0]  PBUS_OUT,
  output logic             PBUS_OE,
  output logic             PXSWAP,
  output logic             LD1,
  output logic             LD2,
  output logic             CK1,
  output logic             CK2,
  output logic             CK3,
  output logic             CK4,
  output logic             WE1,
  output logic             WE2,
  output logic             WE3,
  output logic             WE4,
  output logic             SS1,
  output logic             SS2,
  output logic             TMS0,
  output logic             PCK2,
  output logic [7:0]       LATE_CNT
);

  localparam int NPAIR = SPR_W / 2;
  localparam int CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  if (SPR_W < 2 || (SPR_W % 2) != 0 || VIS_W < 1 || VIS_W > 1023) begin : g_bad_cfg
    $error("neo_lb_ctrl: SPR_W must be even and >= 2, VIS_W in 1..1023");
  end

  lb_state_e        r_state;
  logic             r_ready;
  logic             r_oe;
  logic [PB_W-1:0]  r_pbus;
  logic             r_pxswap;
  logic             r_tms0;
  logic [7:0]       r_late;
  logic [CW-1:0]    r_cnt;

  logic       w_ls;
  logic       w_hs;
  logic [9:0] w_x1;
  logic       w_load_t, w_linit_t, w_wa_t, w_wb_t;
  logic       w_we_l, w_we_r;
  logic       w_clip_l, w_clip_r;
  logic       w_fck1, w_fck2;

  // LINE_START only counts on a pixel tick and overrides everything else.
  assign w_ls = LINE_START & PIX_EN;
  // r_ready is only ever high in IDLE; a handshake coinciding with a line
  // start is refused.
  assign w_hs = JOB_VALID & r_ready & ~w_ls;
  // X+1 kept 10 bits wide so X=511 yields L address 0 in the low byte.
  assign w_x1 = {1'b0, JOB_X} + 10'd1;

  // Strobes are decoded from the registered state and qualified by the
  // pixel tick itself, so each is exactly one CLK and lines up with PIX_EN.
  assign w_load_t  = (r_state == ST_LOAD)  & PIX_EN & ~w_ls;
  assign w_linit_t = (r_state == ST_LINIT) & PIX_EN & ~w_ls;
  assign w_wa_t    = (r_state == ST_WA)    & PIX_EN & ~w_ls;
  assign w_wb_t    = (r_state == ST_WB)    & PIX_EN & ~w_ls;

`ifdef NEO_LB_CLIP_EN
  // Screen X of the pixel currently headed for each back-pair buffer.
  // L buffers hold even pixels, R buffers odd pixels.
  logic [10:0] r_xl, r_xr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_xl <= '0;
      r_xr <= '0;
    end else if (w_hs) begin
      r_xl <= {1'b0, w_x1[9:1], 1'b0};
      r_xr <= {2'b00, JOB_X[8:1], 1'b1};
    end else if (w_wb_t) begin
      r_xl <= r_xl + 11'd2;
      r_xr <= r_xr + 11'd2;
    end
  end

  assign w_clip_l = (r_xl >= 11'(VIS_W));
  assign w_clip_r = (r_xr >= 11'(VIS_W));
`else
  assign w_clip_l = 1'b0;
  assign w_clip_r = 1'b0;
`endif

  assign w_we_l = w_wa_t & (GAD != 4'd0) & ~w_clip_l;
  assign w_we_r = w_wa_t & (GBD != 4'd0) & ~w_clip_r;

  // Render FSM
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_oe     <= 1'b0;
      r_pbus   <= '0;
      r_pxswap <= 1'b0;
      r_tms0   <= 1'b0;
      r_late   <= '0;
      r_cnt    <= '0;
    end else if (w_ls) begin
      r_tms0  <= ~r_tms0;
      r_state <= ST_LINIT;
      r_ready <= 1'b0;
      r_oe    <= 1'b1;
      r_pbus  <= '0;
      if ((r_state inside {ST_LOAD, ST_WA, ST_WB}) && (r_late != 8'hFF))
        r_late <= r_late + 8'd1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_pbus   <= pbus_pack(JOB_PAL, JOB_X[8:1], w_x1[8:1]);
            r_pxswap <= JOB_X[0];
            r_oe     <= 1'b1;
            r_ready  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LINIT: begin
          if (PIX_EN) begin
            r_oe    <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (PIX_EN) begin
            r_oe    <= 1'b0;
            r_state <= ST_WA;
          end
        end
        ST_WA: begin
          if (PIX_EN) r_state <= ST_WB;
        end
        ST_WB: begin
          if (PIX_EN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(NPAIR - 1)) begin
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WA;
            end
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_oe    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  neo_lb_ctrl_disp u_disp (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_pix_en (PIX_EN),
    .i_disp   (DISP_ACTIVE),
    .i_tms0   (r_tms0),
    .o_ck_p1  (w_fck1),
    .o_ck_p2  (w_fck2),
    .o_ss1    (SS1),
    .o_ss2    (SS2)
  );

  // Back pair is pair 1 when r_tms0=1, pair 2 when r_tms0=0. LINIT loads the
  // (new) front pair, LOAD loads the back pair.
  assign LD1  = (w_load_t &  r_tms0) | (w_linit_t & ~r_tms0);
  assign LD2  = (w_load_t & ~r_tms0) | (w_linit_t &  r_tms0);
  assign PCK2 = w_load_t;

  assign WE1 = w_we_l &  r_tms0;
  assign WE2 = w_we_r &  r_tms0;
  assign WE3 = w_we_l & ~r_tms0;
  assign WE4 = w_we_r & ~r_tms0;

  // Render and display clocks never target the same pair, so OR them.
  assign CK1 = (w_wb_t &  r_tms0) | w_fck1;
  assign CK2 = (w_wb_t &  r_tms0) | w_fck1;
  assign CK3 = (w_wb_t & ~r_tms0) | w_fck2;
  assign CK4 = (w_wb_t & ~r_tms0) | w_fck2;

  assign JOB_READY = r_ready;
  assign PBUS_OUT  = r_pbus;
  assign PBUS_OE   = r_oe;
  assign PXSWAP    = r_pxswap;
  assign TMS0      = r_tms0;
  assign LATE_CNT  = r_late;

endmodule

// File: tb/tb_neo_lb_ctrl.sv
module tb_neo_lb_ctrl;
  localparam int SPR_W = 16;
  localparam int VIS_W = 320;

  logic        CLK = 1'b0, nRST = 1'b0, PIX_EN = 1'b0, LINE_START = 1'b0;
  logic        DISP_ACTIVE = 1'b0, JOB_VALID = 1'b0;
  logic [8:0]  JOB_X = '0;
  logic [7:0]  JOB_PAL = '0;
  logic [3:0]  GAD = '0, GBD = '0;
  logic        JOB_READY, PBUS_OE, PXSWAP, LD1, LD2, CK1, CK2, CK3, CK4;
  logic        WE1, WE2, WE3, WE4, SS1, SS2, TMS0, PCK2;
  logic [23:0] PBUS_OUT;
  logic [7:0]  LATE_CNT;

  neo_lb_ctrl #(.SPR_W(SPR_W), .VIS_W(VIS_W)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_EN(PIX_EN), .LINE_START(LINE_START),
    .DISP_ACTIVE(DISP_ACTIVE), .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
    .JOB_X(JOB_X), .JOB_PAL(JOB_PAL), .GAD(GAD), .GBD(GBD),
    .PBUS_OUT(PBUS_OUT), .PBUS_OE(PBUS_OE), .PXSWAP(PXSWAP),
    .LD1(LD1), .LD2(LD2), .CK1(CK1), .CK2(CK2), .CK3(CK3), .CK4(CK4),
    .WE1(WE1), .WE2(WE2), .WE3(WE3), .WE4(WE4), .SS1(SS1), .SS2(SS2),
    .TMS0(TMS0), .PCK2(PCK2), .LATE_CNT(LATE_CNT)
  );

  always #5 CLK = ~CLK;

  // Pixel tick every second clock.
  initial forever begin
    @(posedge CLK);
    #1 PIX_EN = ~PIX_EN;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected-response queues
  logic [37:0] q_ld[$];   // {LD1,LD2,PCK2,OE,TMS0,PXSWAP,LATE[7:0],PBUS[23:0]}
  logic [71:0] q_job[$];  // {WE1..WE4,CK1..CK4,ticks}, 8 bits each
  logic [37:0] q_dsp[$];  // {CK1..CK4 (9b each), SS1 always, SS2 ever}

  // Bench model state
  bit       e_tms = 0, e_px = 0, e_inflight = 0;
  int       e_late = 0;

  function automatic logic [37:0] ld_rec(bit l1, bit l2, bit pck, bit oe, bit tms, bit px,
                                         logic [7:0] late, logic [23:0] pbus);
    return {l1, l2, pck, oe, tms, px, late, pbus};
  endfunction

  // Pixel px goes to the L buffer when even, R buffer when odd.
  function automatic logic [71:0] job_rec(int x, logic [3:0] a, logic [3:0] b, bit tms);
    int wl = 0, wr = 0;
    for (int i = 0; i < SPR_W; i++) begin
      int px = x + i;
      bit odd = (px % 2) == 1;
      bit opq = odd ? (b != 0) : (a != 0);
      bit vis = 1'b1;
`ifdef NEO_LB_CLIP_EN
      vis = (px < VIS_W);
`endif
      if (opq && vis) begin
        if (odd) wr++;
        else     wl++;
      end
    end
    if (tms) return {8'(wl), 8'(wr), 8'd0, 8'd0, 8'(SPR_W/2), 8'(SPR_W/2), 8'd0, 8'd0, 8'(SPR_W+1)};
    else     return {8'd0, 8'd0, 8'(wl), 8'(wr), 8'd0, 8'd0, 8'(SPR_W/2), 8'(SPR_W/2), 8'(SPR_W+1)};
  endfunction

  // Monitor
  bit         ja = 0, d_prev = 0, d_ss1 = 1, d_ss2 = 0;
  logic [7:0] a_we1, a_we2, a_we3, a_we4, a_ck1, a_ck2, a_ck3, a_ck4, a_tk;
  logic [8:0] d_ck1 = 0, d_ck2 = 0, d_ck3 = 0, d_ck4 = 0;

  always @(negedge CLK) begin
    if (nRST) begin
      if (LD1 || LD2) begin
        if (q_ld.size() == 0) begin
          n_tot++;
          $display("FAIL ld_unexpected: got %0h expected none",
                   {LD1, LD2, PCK2, PBUS_OE, TMS0, PXSWAP, LATE_CNT, PBUS_OUT});
        end else
          chk("ld_event", {LD1, LD2, PCK2, PBUS_OE, TMS0, PXSWAP, LATE_CNT, PBUS_OUT},
              q_ld.pop_front());
        ja = PCK2;
        {a_we1, a_we2, a_we3, a_we4, a_ck1, a_ck2, a_ck3, a_ck4, a_tk} = '0;
      end
      if (ja && !JOB_READY) begin
        if (PIX_EN) a_tk++;
        a_we1 += 8'(WE1); a_we2 += 8'(WE2); a_we3 += 8'(WE3); a_we4 += 8'(WE4);
        a_ck1 += 8'(CK1); a_ck2 += 8'(CK2); a_ck3 += 8'(CK3); a_ck4 += 8'(CK4);
      end else if (ja && JOB_READY) begin
        ja = 0;
        if (q_job.size() == 0) begin
          n_tot++;
          $display("FAIL job_unexpected: got completion expected none");
        end else
          chk("job_summary", {a_we1, a_we2, a_we3, a_we4, a_ck1, a_ck2, a_ck3, a_ck4, a_tk},
              q_job.pop_front());
      end
      if (DISP_ACTIVE) begin
        d_ck1 += 9'(CK1); d_ck2 += 9'(CK2); d_ck3 += 9'(CK3); d_ck4 += 9'(CK4);
        d_ss1 &= SS1; d_ss2 |= SS2;
        d_prev = 1;
      end else if (d_prev) begin
        d_prev = 0;
        if (q_dsp.size() == 0) begin
          n_tot++;
          $display("FAIL disp_unexpected: got window expected none");
        end else
          chk("disp_window", {d_ck1, d_ck2, d_ck3, d_ck4, d_ss1, d_ss2}, q_dsp.pop_front());
        {d_ck1, d_ck2, d_ck3, d_ck4} = '0;
        d_ss1 = 1; d_ss2 = 0;
      end
    end
  end

  // Returns just before a clock edge on which PIX_EN is high.
  task automatic pix_cycle();
    @(posedge CLK); #2;
    while (!PIX_EN) begin @(posedge CLK); #2; end
  endtask

  task automatic line_start(input bit with_valid);
    pix_cycle();
    LINE_START = 1'b1;
    if (with_valid) JOB_VALID = 1'b1;
    @(posedge CLK); #2;
    LINE_START = 1'b0;
    JOB_VALID  = 1'b0;
    e_tms = ~e_tms;
    if (e_inflight && e_late < 255) e_late++;
    e_inflight = 0;
    q_ld.push_back(ld_rec(~e_tms, e_tms, 1'b0, 1'b1, e_tms, e_px, 8'(e_late), 24'h0));
  endtask

  task automatic job_start(input logic [8:0] x, input logic [7:0] pal,
                           input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    logic [9:0] lv;
    while (!JOB_READY && n < 100) begin @(posedge CLK); #2; n++; end
    if (!JOB_READY) begin n_tot++; $display("FAIL ready_wait: got 0 expected 1"); end
    JOB_X = x; JOB_PAL = pal; GAD = a; GBD = b; JOB_VALID = 1'b1;
    @(posedge CLK); #2;
    JOB_VALID = 1'b0;
    e_px = x[0];
    e_inflight = 1;
    lv = {1'b0, x} + 10'd1;
    q_ld.push_back(ld_rec(e_tms, ~e_tms, 1'b1, 1'b1, e_tms, x[0], 8'(e_late),
                          {pal, x[8:1], lv[8:1]}));
  endtask

  task automatic job(input logic [8:0] x, input logic [7:0] pal,
                     input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    job_start(x, pal, a, b);
    q_job.push_back(job_rec(int'(x), a, b, e_tms));
    while (!JOB_READY && n < 400) begin @(posedge CLK); #2; n++; end
    if (!JOB_READY) begin n_tot++; $display("FAIL job_done_wait: got 0 expected 1"); end
    e_inflight = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge CLK);
    #2;
    chk("rst_tms0",    TMS0, 0);
    chk("rst_ready",   JOB_READY, 1);
    chk("rst_late",    LATE_CNT, 0);
    chk("rst_pbus",    {PBUS_OE, PBUS_OUT}, 0);
    chk("rst_strobes", {LD1, LD2, CK1, CK2, CK3, CK4, WE1, WE2, WE3, WE4, PCK2, SS1, SS2}, 0);
    nRST = 1'b1;

    line_start(0);                   // TMS0 -> 1, front pair 2 loaded
    pix_cycle(); pix_cycle();
    chk("flip_tms0",  TMS0, 1);
    chk("linit_ready", JOB_READY, 1);
    line_start(0);                   // TMS0 -> 0, back pair is pair 2

    job(9'd100, 8'h2A, 4'd5, 4'd3);  // PBUS 0x2A3232, all opaque
    job(9'd7,   8'h11, 4'd0, 4'd9);  // L=4, R=3, no L writes, PXSWAP=1
    job(9'd316, 8'h33, 4'd1, 4'd1);  // right-edge clipping case
    job(9'd511, 8'h80, 4'd2, 4'd2);  // L address wraps to 0

    // Abort 5 ticks into a job
    job_start(9'd20, 8'h44, 4'd1, 4'd1);
    repeat (5) pix_cycle();
    line_start(0);
    pix_cycle(); pix_cycle();
    chk("abort_late", LATE_CNT, 1);

    // Handshake coinciding with LINE_START is refused
    line_start(1);
    repeat (6) pix_cycle();
    chk("refused_ready", JOB_READY, 1);
    chk("refused_late",  LATE_CNT, 8'(e_late));

    // 255 more aborts; counter saturates
    for (int i = 0; i < 255; i++) begin
      job_start(9'(i * 2), 8'(i), 4'd1, 4'd0);
      pix_cycle(); pix_cycle();
      line_start(0);
    end
    pix_cycle(); pix_cycle();
    chk("late_sat", LATE_CNT, 8'd255);

    // Display side with pair 1 in front
    if (e_tms) line_start(0);
    pix_cycle(); pix_cycle();
    q_dsp.push_back({9'd160, 9'd160, 9'd0, 9'd0, 1'b1, 1'b0});
    DISP_ACTIVE = 1'b1;
    repeat (320) pix_cycle();
    DISP_ACTIVE = 1'b0;
    repeat (4) pix_cycle();

    chk("q_ld_drained",  q_ld.size(), 0);
    chk("q_job_drained", q_job.size(), 0);
    chk("q_dsp_drained", q_dsp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
